// File: rtl/sprite_linebuf.sv
// Double-buffered sprite scanline store: the renderer composes into one bank
// while the display reads and clears the other; banks swap at end of line.
//
// state    | meaning
// ST_CLEAR | zeroing all 512 entries after reset, writes blocked
// ST_IDLE  | ready for a renderer write
// ST_RMW   | second half of read-modify-write, conditional store
module sprite_linebuf #(
  parameter int PIX_W  = 8,
  parameter int HSTART = 16,
  parameter int HLAST  = 383,
  parameter int VLAST  = 262
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic [8:0]       hcount,
  input  logic [8:0]       vcount,
  input  logic             vb,
  input  logic             wr_en,
  input  logic [7:0]       wr_x,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_ready,
  output logic [8:0]       wr_vline,
  output logic             swap,
  output logic [PIX_W-1:0] pix_out
);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_RMW   = 2'd2;

  localparam logic [8:0] HSTART_C = 9'(HSTART);
  localparam logic [8:0] HEND_C   = 9'(HSTART + 255);
  localparam logic [8:0] HLAST_C  = 9'(HLAST);
  localparam logic [8:0] VLAST_C  = 9'(VLAST);

  logic [PIX_W-1:0] mem [512];

  logic [1:0]       state_q, state_d;
  logic [8:0]       clr_addr_q, clr_addr_d;
  logic             wbank_q, wbank_d;
  logic [8:0]       wr_vline_q, wr_vline_d;
  logic             swap_q, swap_d;
  logic [8:0]       rmw_addr_q, rmw_addr_d;
  logic [PIX_W-1:0] rmw_data_q, rmw_data_d;
  logic [3:0]       a_rdata_q;
  logic [PIX_W-1:0] b_rdata_q;
  logic             disp_pend_q, disp_pend_d;
  logic             disp_in_q, disp_in_d;
  logic [8:0]       disp_addr_q, disp_addr_d;
  logic [PIX_W-1:0] pix_q, pix_d;

  logic             clearing;
  logic             swap_evt;
  logic             in_win;
  logic [7:0]       hoff;
  logic             a_we;
  logic             a_re;
  logic [8:0]       a_addr;
  logic [PIX_W-1:0] a_wdata;
  logic             b_re;
  logic             b_we;
  logic [8:0]       b_addr;

  assign clearing = (state_q == ST_CLEAR);
  assign wr_ready = (state_q == ST_IDLE);
  assign swap_evt = ce_pix && (hcount == HLAST_C);
  assign in_win   = (hcount >= HSTART_C) && (hcount <= HEND_C);
  assign hoff     = 8'(hcount - HSTART_C);

  // Write side: clear walk, then one RMW per two clocks.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    rmw_addr_d = rmw_addr_q;
    rmw_data_d = rmw_data_q;
    a_we       = 1'b0;
    a_re       = 1'b0;
    a_addr     = clr_addr_q;
    a_wdata    = '0;
    case (state_q)
      ST_CLEAR: begin
        a_we       = 1'b1;
        clr_addr_d = clr_addr_q + 9'd1;
        if (clr_addr_q == 9'd511) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (wr_en) begin
          a_re       = 1'b1;
          a_addr     = {wbank_q, wr_x};
          rmw_addr_d = {wbank_q, wr_x};
          rmw_data_d = wr_data;
          state_d    = ST_RMW;
        end
      end
      ST_RMW: begin
        // first opaque pixel wins; transparent writes never store
        a_addr  = rmw_addr_q;
        a_wdata = rmw_data_q;
        a_we    = (a_rdata_q == 4'd0) && (rmw_data_q[3:0] != 4'd0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    wbank_d    = wbank_q ^ swap_evt;
    wr_vline_d = wr_vline_q;
    if (swap_evt) wr_vline_d = (vcount == VLAST_C) ? 9'd0 : vcount + 9'd1;
    swap_d     = swap_evt;
  end

  // Display side: read at the ce_pix edge, show and clear one clock later.
  always_comb begin
    b_addr      = {~wbank_q, hoff};
    b_re        = ce_pix && in_win && !clearing;
    b_we        = disp_pend_q && disp_in_q;
    disp_pend_d = ce_pix;
    disp_in_d   = ce_pix && in_win && !clearing;
    disp_addr_d = b_addr;
    pix_d       = pix_q;
    if (disp_pend_q) pix_d = (disp_in_q && !vb) ? b_rdata_q : '0;
  end

  always_ff @(posedge clk) begin
    if (a_re) a_rdata_q <= mem[a_addr][3:0];
    if (a_we && !reset) mem[a_addr] <= a_wdata;
    if (b_re) b_rdata_q <= mem[b_addr];
    if (b_we && !reset) mem[disp_addr_q] <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      wbank_q     <= 1'b0;
      wr_vline_q  <= '0;
      swap_q      <= 1'b0;
      rmw_addr_q  <= '0;
      rmw_data_q  <= '0;
      disp_pend_q <= 1'b0;
      disp_in_q   <= 1'b0;
      disp_addr_q <= '0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      wbank_q     <= wbank_d;
      wr_vline_q  <= wr_vline_d;
      swap_q      <= swap_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_data_q  <= rmw_data_d;
      disp_pend_q <= disp_pend_d;
      disp_in_q   <= disp_in_d;
      disp_addr_q <= disp_addr_d;
      pix_q       <= pix_d;
    end
  end

  assign wr_vline = wr_vline_q;
  assign swap     = swap_q;
  assign pix_out  = pix_q;

endmodule

// File: tb/tb_sprite_linebuf.sv
// Bench for sprite_linebuf: line-image model plus directed scenarios with
// hand-computed pixel, handshake and line-number expectations.
module tb_sprite_linebuf;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_pix = 1'b0;
  logic [8:0] hcount = '0;
  logic [8:0] vcount = '0;
  logic       vb = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_x = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic [8:0] wr_vline;
  logic       swap;
  logic [7:0] pix_out;

  sprite_linebuf dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .hcount(hcount),
    .vcount(vcount), .vb(vb), .wr_en(wr_en), .wr_x(wr_x),
    .wr_data(wr_data), .wr_ready(wr_ready), .wr_vline(wr_vline),
    .swap(swap), .pix_out(pix_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ce_div = 2;
  bit vb_force = 1'b0;
  bit chk_on = 1'b0;

  // Model: two 256-entry line images, write bank index, pending work.
  logic [7:0] m_line [2][256];
  int         m_clr;
  bit         m_wbank, m_busy, m_pb;
  logic [7:0] m_px, m_pd;
  bit         m_e2, m_e2_in, m_e2_bank;
  logic [7:0] m_e2_x;
  bit         m_clearing;
  bit         e_ready, e_swap;
  logic [8:0] e_vline;
  logic [7:0] e_pix;

  always @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int x = 0; x < 256; x++) m_line[b][x] = 8'h00;
      m_clr = 512; m_wbank = 0; m_busy = 0; m_e2 = 0; m_e2_in = 0;
      e_ready = 0; e_swap = 0; e_vline = '0; e_pix = '0;
      chk_on = 1'b1;
    end else begin
      m_clearing = (m_clr > 0);
      if (m_e2) begin
        if (m_e2_in) begin
          e_pix = vb ? 8'h00 : m_line[m_e2_bank][m_e2_x];
          m_line[m_e2_bank][m_e2_x] = 8'h00;
        end else e_pix = 8'h00;
      end
      m_e2 = ce_pix;
      if (ce_pix) begin
        m_e2_in   = (hcount >= 9'd16) && (hcount <= 9'd271) && !m_clearing;
        m_e2_bank = !m_wbank;
        m_e2_x    = 8'(hcount - 9'd16);
      end
      if (m_busy) begin
        if (m_line[m_pb][m_px][3:0] == 4'd0 && m_pd[3:0] != 4'd0) m_line[m_pb][m_px] = m_pd;
        m_busy = 0;
      end else if (wr_en && e_ready) begin
        m_busy = 1; m_pb = m_wbank; m_px = wr_x; m_pd = wr_data;
      end
      e_swap = ce_pix && (hcount == 9'd383);
      if (e_swap) begin
        m_wbank = !m_wbank;
        e_vline = (vcount == 9'd262) ? 9'd0 : vcount + 9'd1;
      end
      if (m_clr > 0) m_clr--;
      e_ready = (m_clr == 0) && !m_busy;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("wr_ready", 32'(wr_ready), 32'(e_ready));
      check("pix_out", 32'(pix_out), 32'(e_pix));
      check("swap", 32'(swap), 32'(e_swap));
      check("wr_vline", 32'(wr_vline), 32'(e_vline));
    end
  end

  // Bench-side timing generator advances on each clock.
  task automatic tick();
    @(posedge clk); #1;
    if (ce_pix) begin
      if (hcount == 9'd383) begin
        hcount = '0;
        vcount = (vcount == 9'd262) ? 9'd0 : vcount + 9'd1;
      end else hcount = hcount + 9'd1;
    end
    ce_pix = (ce_div == 1) ? 1'b1 : ~ce_pix;
    vb = (vcount >= 9'd240) || vb_force;
  endtask

  task automatic wait_h(input logic [8:0] h);
    int n = 0;
    while (!(ce_pix && hcount == h) && n < 2000) begin tick(); n++; end
    if (n >= 2000) begin
      n_vec++; n_err++;
      $display("FAIL wait_h timeout: hcount %0d never reached, wanted %0d", hcount, h);
    end
  endtask

  task automatic wait_swap();
    wait_h(9'd383);
    tick();
  endtask

  task automatic wr_pix(input logic [7:0] x, input logic [7:0] d);
    int n = 0;
    wr_en = 1'b1; wr_x = x; wr_data = d;
    while (!e_ready && n < 600) begin tick(); n++; end
    if (n >= 600) begin
      n_vec++; n_err++;
      $display("FAIL wr_accept timeout: ready %0b, expected 1", wr_ready);
    end
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    for (int i = 0; i < 511; i++) tick();
    check("ready_in_clear", 32'(wr_ready), 32'd0);
    check("pix_in_clear", 32'(pix_out), 32'd0);
    tick();
    check("ready_after_clear", 32'(wr_ready), 32'd1);

    // first-opaque-wins and transparent writes
    wait_swap();
    wr_pix(8'd5, 8'h23); wr_pix(8'd10, 8'h14); wr_pix(8'd10, 8'h37); wr_pix(8'd11, 8'h30);
    wait_swap();
    wait_h(9'd21); tick();
    check("x5_one_clk", 32'(pix_out), 32'h00);
    tick();
    check("x5_disp", 32'(pix_out), 32'h23);
    wait_h(9'd26); tick(); tick();
    check("x10_first_wins", 32'(pix_out), 32'h14);
    wait_h(9'd27); tick(); tick();
    check("x11_transparent", 32'(pix_out), 32'h00);
    wait_swap(); wait_swap();
    wait_h(9'd21); tick(); tick();
    check("x5_cleared", 32'(pix_out), 32'h00);

    // continuous wr_en: one accept per two clocks
    wait_swap();
    wr_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wr_x = 8'(200 + k); wr_data = 8'(8'h05 + k);
      check("ready_toggle", 32'(wr_ready), 32'((k % 2) == 0));
      tick();
    end
    wr_en = 1'b0;
    wait_swap();
    wait_h(9'd218); tick(); tick();
    check("burst_x202", 32'(pix_out), 32'h07);
    wait_h(9'd219); tick(); tick();
    check("burst_x203_skipped", 32'(pix_out), 32'h00);

    // accept one clock before the swap edge
    wait_h(9'd382); tick();
    wr_en = 1'b1; wr_x = 8'd50; wr_data = 8'h09;
    check("straddle_ready", 32'(wr_ready), 32'd1);
    tick(); wr_en = 1'b0;
    tick();
    wait_h(9'd66); tick(); tick();
    check("straddle_x50", 32'(pix_out), 32'h09);

    // edges of the window with ce_pix every clock, and line numbering
    wait_swap();
    wr_pix(8'd0, 8'h11); wr_pix(8'd255, 8'h2F); wr_pix(8'd128, 8'hA6);
    vcount = 9'd100;
    wait_h(9'd383); tick();
    check("vline_101", 32'(wr_vline), 32'd101);
    check("swap_pulse", 32'(swap), 32'd1);
    ce_div = 1; ce_pix = 1'b1;
    tick();
    check("swap_width", 32'(swap), 32'd0);
    wr_pix(8'd20, 8'h44);
    wait_h(9'd16); tick(); tick();
    check("x0_fast", 32'(pix_out), 32'h11);
    wait_h(9'd271); tick(); tick();
    check("x255_fast", 32'(pix_out), 32'h2F);
    tick();
    check("after_window", 32'(pix_out), 32'h00);
    vcount = 9'd262;
    wait_h(9'd383); tick();
    check("vline_wrap", 32'(wr_vline), 32'd0);
    vb_force = 1'b1; vb = 1'b1;
    wait_h(9'd36); tick(); tick();
    check("vb_blank", 32'(pix_out), 32'h00);
    vb_force = 1'b0;
    ce_div = 2;

    // reset in the middle of an RMW and a displayed line
    wait_swap();
    wr_pix(8'd100, 8'h0C);
    wait_swap();
    wait_h(9'd116); tick(); tick();
    check("pre_reset_pix", 32'(pix_out), 32'h0C);
    wr_en = 1'b1; wr_x = 8'd3; wr_data = 8'h0D;
    tick(); wr_en = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("reset_pix", 32'(pix_out), 32'h00);
    check("reset_ready", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 511; i++) tick();
    check("reclear_ready_low", 32'(wr_ready), 32'd0);
    tick();
    check("reclear_ready_high", 32'(wr_ready), 32'd1);
    wait_swap(); wait_swap(); wait_swap();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
